// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: flush FSM state encoding and default parameters for the FIFO write arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        CLR  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int NREQ_DEF      = 4;
    localparam int DSIZE_DEF     = 8;
    localparam int ASIZE_DEF     = 4;
    localparam int CLR_WAIT_DEF  = 3;
    localparam int BURST_LEN_DEF = 4;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: one-hot round-robin pick of the first valid requester after i_last.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
)(
    input  logic [NREQ-1:0]         i_vld,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_gnt
);

    localparam int GW = $clog2(NREQ);

    logic [GW-1:0] w_idx;
    logic          w_hit;

    always_comb begin
        o_gnt = '0;
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = GW'((int'(i_last) + k) % NREQ);
            if (!w_hit && i_vld[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter in front of a FIFO with a write-pointer flush sequence.
// Define FIFO_WR_ARB_BURST_EN to let a granted requester keep the port for up to BURST_LEN beats.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ASIZE     = ASIZE_DEF,
    parameter int CLR_WAIT  = CLR_WAIT_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
)(
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_vld,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_rdy,
    input  logic                    flush_req,
    output logic                    flush_done,
    input  logic [ASIZE-1:0]        cfg_mrgn,
    input  logic                    full,
    input  logic                    over_flow,
    output logic                    wen,
    output logic [DSIZE-1:0]        wdata,
    output logic                    wptr_clr,
    output logic [ASIZE-1:0]        near_full_mrgn,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    ovf_err
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(CLR_WAIT + 2);

    state_t           r_state;
    logic [CW-1:0]    r_wcnt;
    logic [GW-1:0]    r_gid;
    logic             r_ovf;
    logic [ASIZE-1:0] r_mrgn;

    logic [NREQ-1:0]  w_rr;
    logic [NREQ-1:0]  w_rdy;
    logic [NREQ-1:0]  w_xfer;
    logic [GW-1:0]    w_xid;
    logic             w_lock;
    logic             w_accept;
    logic             w_last_wait;

    rr_pick #(.NREQ(NREQ)) u_rr (
        .i_vld  (req_vld),
        .i_last (r_gid),
        .o_gnt  (w_rr)
    );

    assign w_accept    = (r_state == ARB) && flush_req;
    assign w_last_wait = (r_state == WAIT) && (r_wcnt == CW'(CLR_WAIT));

    // a pending flush outranks any transfer in the same cycle
    assign w_rdy  = (r_state == ARB && !full && !flush_req) ?
                    (w_lock ? (NREQ'(1) << r_gid) : w_rr) : '0;
    assign w_xfer = req_vld & w_rdy;

    assign req_rdy        = w_rdy;
    assign wen            = |w_xfer;
    assign wptr_clr       = (r_state == CLR);
    assign flush_done     = w_last_wait;
    assign near_full_mrgn = r_mrgn;
    assign grant_id       = r_gid;
    assign ovf_err        = r_ovf;

    always_comb begin
        wdata = '0;
        w_xid = r_gid;
        for (int i = 0; i < NREQ; i++) begin
            if (w_xfer[i]) begin
                wdata = req_data[i*DSIZE +: DSIZE];
                w_xid = GW'(i);
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state <= ARB;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_accept ? CLR : (r_state == CLR) ? WAIT : w_last_wait ? ARB : r_state;
            r_wcnt  <= (r_state == WAIT && !w_last_wait) ? r_wcnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_gid  <= GW'(NREQ - 1);
            r_ovf  <= 1'b0;
            r_mrgn <= '0;
        end else begin
            r_gid  <= wen ? w_xid : r_gid;
            r_ovf  <= over_flow | (r_ovf & ~w_accept);
            r_mrgn <= cfg_mrgn;
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);

    logic [BW-1:0] r_beats;

    // full stalls the transfer but leaves r_beats untouched, so the lock survives
    assign w_lock = (r_beats != '0) && (r_beats < BW'(BURST_LEN)) && req_vld[r_gid];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)
            r_beats <= '0;
        else
            r_beats <= w_accept ? '0 :
                       wen ? (w_lock ? r_beats + 1'b1 : BW'(1)) :
                       req_vld[r_gid] ? r_beats : '0;
    end
`else
    assign w_lock = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: randomized and directed checks of fifo_wr_arb against a cycle-level behavioural model.
module tb_fifo_wr_arb;
    import fifo_wr_arb_pkg::*;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int ASIZE     = 4;
    localparam int CLR_WAIT  = 3;
    localparam int BURST_LEN = 4;
    localparam int GW        = 2;
`ifdef FIFO_WR_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                  wclk;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_vld;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_rdy;
    logic                  flush_req;
    logic                  flush_done;
    logic [ASIZE-1:0]      cfg_mrgn;
    logic                  full;
    logic                  over_flow;
    logic                  wen;
    logic [DSIZE-1:0]      wdata;
    logic                  wptr_clr;
    logic [ASIZE-1:0]      near_full_mrgn;
    logic [GW-1:0]         grant_id;
    logic                  ovf_err;

    fifo_wr_arb #(
        .NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE), .CLR_WAIT(CLR_WAIT), .BURST_LEN(BURST_LEN)
    ) dut (
        .wclk           (wclk),
        .wrst_n         (wrst_n),
        .req_vld        (req_vld),
        .req_data       (req_data),
        .req_rdy        (req_rdy),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .cfg_mrgn       (cfg_mrgn),
        .full           (full),
        .over_flow      (over_flow),
        .wen            (wen),
        .wdata          (wdata),
        .wptr_clr       (wptr_clr),
        .near_full_mrgn (near_full_mrgn),
        .grant_id       (grant_id),
        .ovf_err        (ovf_err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: last served index, beats in current burst, cycles since a flush was accepted
    logic [GW-1:0]    m_last;
    int               m_fl;
    int               m_bl;
    logic             m_ovf;
    logic [ASIZE-1:0] m_mrgn;

    always @(negedge wclk) begin : model_cmp
        int              e_idx;
        bit              e_lock;
        bit              e_acc;
        logic [NREQ-1:0] e_rdy;
        logic [DSIZE-1:0] e_wd;
        logic [GW-1:0]   j;
        if (!wrst_n) begin
            m_last = GW'(NREQ - 1);
            m_fl   = 0;
            m_bl   = 0;
            m_ovf  = 1'b0;
            m_mrgn = '0;
        end
        e_idx  = -1;
        e_lock = BURST && m_bl > 0 && m_bl < BURST_LEN && req_vld[m_last];
        if (m_fl == 0 && !full && !flush_req) begin
            if (e_lock)
                e_idx = int'(m_last);
            else
                for (int k = 1; k <= NREQ; k++) begin
                    j = GW'((int'(m_last) + k) % NREQ);
                    if (e_idx < 0 && req_vld[j]) e_idx = int'(j);
                end
        end
        e_rdy = '0;
        e_wd  = '0;
        if (e_idx >= 0) begin
            e_rdy[e_idx] = 1'b1;
            e_wd = req_data[e_idx*DSIZE +: DSIZE];
        end
        chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
        chk("wen", 32'(wen), 32'(e_idx >= 0));
        chk("wdata", 32'(wdata), 32'(e_wd));
        chk("wptr_clr", 32'(wptr_clr), 32'(m_fl == 1));
        chk("flush_done", 32'(flush_done), 32'(m_fl == CLR_WAIT + 2));
        chk("grant_id", 32'(grant_id), 32'(m_last));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("near_full_mrgn", 32'(near_full_mrgn), 32'(m_mrgn));
        if (wrst_n) begin
            e_acc = (m_fl == 0) && flush_req;
            if (e_idx >= 0) begin
                m_bl   = (e_lock && e_idx == int'(m_last)) ? m_bl + 1 : 1;
                m_last = GW'(e_idx);
            end else if (!req_vld[m_last]) begin
                m_bl = 0;
            end
            if (e_acc) begin
                m_fl = 1;
                m_bl = 0;
            end else if (m_fl == CLR_WAIT + 2) begin
                m_fl = 0;
            end else if (m_fl > 0) begin
                m_fl++;
            end
            m_ovf  = over_flow ? 1'b1 : (e_acc ? 1'b0 : m_ovf);
            m_mrgn = cfg_mrgn;
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst_n    = 1'b0;
        req_vld   = '0;
        flush_req = 1'b0;
        full      = 1'b0;
        over_flow = 1'b0;
        step();
        step();
        wrst_n = 1'b1;
    endtask

`ifdef FIFO_WR_ARB_BURST_EN
    int g_exp [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [NREQ-1:0] seq_vld = 4'b0011;
`else
    int g_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [NREQ-1:0] seq_vld = 4'b1111;
`endif

    initial begin
        wrst_n    = 1'b0;
        req_vld   = '0;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        flush_req = 1'b0;
        cfg_mrgn  = 4'h5;
        full      = 1'b0;
        over_flow = 1'b0;
        step();
        step();
        wrst_n = 1'b1;

        // served sequence after reset
        req_vld = seq_vld;
        for (int k = 0; k <= 8; k++) begin
            @(negedge wclk);
            if (k < 8) begin
                chk("seq_wen", 32'(wen), 32'd1);
                chk("seq_rdy", 32'(req_rdy), 32'(1) << g_exp[k]);
            end
            if (k > 0) chk("seq_grant", 32'(grant_id), 32'(g_exp[k-1]));
        end
        step();
        do_reset();

        // full blocks everything and does not move the pointer
        full    = 1'b1;
        req_vld = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            chk("full_rdy", 32'(req_rdy), 32'd0);
            chk("full_wen", 32'(wen), 32'd0);
        end
        step();
        full = 1'b0;
        @(negedge wclk);
        chk("after_full_rdy", 32'(req_rdy), 32'b0001);
        chk("after_full_grant", 32'(grant_id), 32'd3);
        step();

        // flush sequence timing
        req_vld   = 4'b1111;
        flush_req = 1'b1;
        @(negedge wclk);
        chk("flush_prio_rdy", 32'(req_rdy), 32'd0);
        step();
        flush_req = 1'b0;
        @(negedge wclk);
        chk("clr_pulse", 32'(wptr_clr), 32'd1);
        chk("clr_wen", 32'(wen), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge wclk);
            chk("wait_done", 32'(flush_done), 32'(c == 4));
            chk("wait_clr", 32'(wptr_clr), 32'd0);
            chk("wait_wen", 32'(wen), 32'd0);
        end
        @(negedge wclk);
        chk("post_flush_wen", 32'(wen), 32'd1);
        chk("post_flush_done", 32'(flush_done), 32'd0);
        step();

        // sticky overflow cleared by the next flush
        over_flow = 1'b1;
        step();
        over_flow = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            chk("ovf_sticky", 32'(ovf_err), 32'd1);
        end
        step();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        @(negedge wclk);
        chk("ovf_cleared", 32'(ovf_err), 32'd0);
        chk("ovf_clr_pulse", 32'(wptr_clr), 32'd1);
        for (int k = 0; k < 5; k++) step();

        // reset in the middle of WAIT aborts the flush
        req_vld   = 4'b1111;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        step();
        wrst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge wclk);
            chk("rst_wait_done", 32'(flush_done), 32'd0);
            chk("rst_wait_clr", 32'(wptr_clr), 32'd0);
        end
        step();
        wrst_n = 1'b1;
        @(negedge wclk);
        chk("rst_first_rdy", 32'(req_rdy), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            @(negedge wclk);
            chk("rst_no_done", 32'(flush_done), 32'd0);
        end

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            step();
            wrst_n    = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 3) == 0) req_vld[i] = ~req_vld[i];
            req_data  = {$urandom};
            flush_req = ($urandom_range(0, 29) == 0);
            full      = ($urandom_range(0, 3) == 0);
            over_flow = ($urandom_range(0, 19) == 0);
            cfg_mrgn  = ASIZE'($urandom);
        end
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
